// File: rtl/cc_pkg.sv
// Shared cache-controller types: transfer direction, line-memory FSM states
// and bus geometry taken from the global defines.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 64
`endif

package cc_pkg;

    localparam int ADDR_W     = `ADDR_BUS_WIDTH;
    localparam int LINE_BYTES = `LINE_SIZE;
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } rw_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR_DATA,
        WR_WAIT,
        RD_WAIT,
        RD_DONE
    } mem_state_t;

    // Transfer counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Line storage: synchronous write, asynchronous read, zero-filled at power-up.
// Not touched by reset, so contents survive an aborted transfer.
module line_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH] = '{default: '0};

    // Single write port, one line per edge.
    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/line_mem_ctrl.sv
// Line memory controller: address phase, then either a write data phase
// with optional wait states or a fixed-latency read, with saturating
// completed-transfer counters.
module line_mem_ctrl
    import cc_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hreq,
    input  logic [ADDR_W-1:0] haddr,
    input  rw_t               hwrite,
    input  logic [LINE_W-1:0] hwdata,
    output logic [LINE_W-1:0] hrdata,
    output logic              hready,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    localparam int OFF     = $clog2(LINE_BYTES);
    localparam int IDX     = $clog2(DEPTH);
    localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    // Wait counters are loaded with latency-1 and leave the state at zero.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WR_LAT > 0) ? WR_LAT - 1 : 0);

    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("line_mem_ctrl: RD_LAT must be >= 1");
    end

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX-1:0]    idx_q, idx_d;
    logic [LINE_W-1:0] hrdata_q, hrdata_d;
    logic [15:0]       rd_cnt_q, rd_cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic              ram_we;
    logic [LINE_W-1:0] ram_rdata;

    // Upper address bits alias and offset bits select bytes within a line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{haddr[ADDR_W-1:OFF+IDX], haddr[OFF-1:0]};

    line_ram #(.DEPTH(DEPTH), .W(LINE_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (hwdata),
        .rdata (ram_rdata)
    );

    // Next-state, wait counting, read capture and counter updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        hrdata_d = hrdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        ram_we   = 1'b0;
        hready   = 1'b1;
        case (state_q)
            IDLE: if (hreq) state_d = ADDR;
            ADDR: begin
                idx_d = haddr[OFF+IDX-1:OFF];
                if (hwrite == WRITE) begin
                    state_d = WR_DATA;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = RD_LOAD;
                end
            end
            WR_DATA: begin
                // A reset on the capture edge wins: the line is not written.
                ram_we   = !rst;
                wr_cnt_d = sat_inc(wr_cnt_q);
                state_d  = (WR_LAT == 0) ? IDLE : WR_WAIT;
                cnt_d    = WR_LOAD;
            end
            WR_WAIT: begin
                hready = 1'b0;
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RD_WAIT: begin
                hready = 1'b0;
                if (cnt_q == '0) begin
                    state_d  = RD_DONE;
                    hrdata_d = ram_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_DONE: begin
                state_d  = IDLE;
                rd_cnt_d = sat_inc(rd_cnt_q);
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            hrdata_q <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            hrdata_q <= hrdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign hrdata = hrdata_q;
    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed bench for line_mem_ctrl with a transaction-level model: each
// transfer task states the expected hready/hrdata/counter timeline and the
// line contents, and one negedge process compares every cycle.
module tb_line_mem_ctrl;
    import cc_pkg::*;

    localparam int DEPTH  = 64;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;
    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int IDX    = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              hreq;
    logic [ADDR_W-1:0] haddr;
    rw_t               hwrite;
    logic [LINE_W-1:0] hwdata;
    logic [LINE_W-1:0] hrdata;
    logic              hready;
    logic [15:0]       rd_cnt, wr_cnt;

    line_mem_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .rst(rst), .hreq(hreq), .haddr(haddr), .hwrite(hwrite),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    logic [LINE_W-1:0] model_mem [DEPTH];
    logic              exp_hready;
    logic [LINE_W-1:0] exp_hrdata;
    logic [15:0]       exp_rd, exp_wr;
    bit                check_en = 1'b0;
    int                total = 0;
    int                bad = 0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("hready", {{(LINE_W-1){1'b0}}, hready}, {{(LINE_W-1){1'b0}}, exp_hready});
            chk("hrdata", hrdata, exp_hrdata);
            chk("rd_cnt", {{(LINE_W-16){1'b0}}, rd_cnt}, {{(LINE_W-16){1'b0}}, exp_rd});
            chk("wr_cnt", {{(LINE_W-16){1'b0}}, wr_cnt}, {{(LINE_W-16){1'b0}}, exp_wr});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        hreq = 1'b0;
        tick();
        rst        = 1'b0;
        exp_hready = 1'b1;
        exp_hrdata = '0;
        exp_rd     = '0;
        exp_wr     = '0;
    endtask

    // One complete transfer starting from an idle cycle; keep leaves hreq high.
    task automatic xfer(input rw_t op, input logic [ADDR_W-1:0] a,
                        input logic [LINE_W-1:0] d, input bit keep);
        int idx = int'(a[OFF+IDX-1:OFF]);
        hreq = 1'b1; exp_hready = 1'b1;
        tick();
        haddr = a; hwrite = op; hwdata = d; hreq = keep;
        tick();
        if (op == WRITE) begin
            tick();
            model_mem[idx] = d;
            if (exp_wr != 16'hFFFF) exp_wr++;
            if (WR_LAT > 0) begin
                exp_hready = 1'b0;
                repeat (WR_LAT) tick();
                exp_hready = 1'b1;
            end
        end else begin
            exp_hready = 1'b0;
            repeat (RD_LAT) tick();
            exp_hready = 1'b1;
            exp_hrdata = model_mem[idx];
            tick();
            if (exp_rd != 16'hFFFF) exp_rd++;
        end
    endtask

    logic [LINE_W-1:0] pat_a5, pat_11, pat_5a, pat_de, pat_zero;

    initial begin
        pat_a5   = {LINE_BYTES{8'hA5}};
        pat_11   = {LINE_BYTES{8'h11}};
        pat_5a   = {LINE_BYTES{8'h5A}};
        pat_de   = {(LINE_W/32){32'hDEADBEEF}};
        pat_zero = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        haddr = '0; hwrite = READ; hwdata = '0; hreq = 1'b0;

        do_reset();
        do_reset();
        check_en = 1'b1;
        chk("reset_hready", {{(LINE_W-1){1'b0}}, hready}, {{(LINE_W-1){1'b0}}, 1'b1});
        chk("reset_hrdata", hrdata, pat_zero);

        // Write line 1, one wait state.
        xfer(WRITE, 32'h40, pat_a5, 1'b0);
        chk("wr_cnt_after_write", {{(LINE_W-16){1'b0}}, wr_cnt}, {{(LINE_W-16){1'b0}}, 16'd1});
        chk("model_line1", model_mem[1], pat_a5);

        // Reset during a read wait state: no completion, no data.
        hreq = 1'b1; tick();
        haddr = 32'h40; hwrite = READ; hreq = 1'b0; tick();
        exp_hready = 1'b0;
        do_reset();
        repeat (4) tick();
        chk("rd_cnt_after_abort", {{(LINE_W-16){1'b0}}, rd_cnt}, {{(LINE_W-16){1'b0}}, 16'd0});

        // Read back: line survives reset.
        xfer(READ, 32'h40, '0, 1'b0);
        chk("read_line1", hrdata, pat_a5);
        chk("rd_cnt_after_read", {{(LINE_W-16){1'b0}}, rd_cnt}, {{(LINE_W-16){1'b0}}, 16'd1});
        tick();
        chk("hrdata_holds", hrdata, pat_a5);

        // Never-written line is zero.
        xfer(READ, 32'h80, '0, 1'b0);
        chk("read_unwritten", hrdata, pat_zero);

        // Aliasing through upper address bits, offset bits ignored on read.
        xfer(WRITE, 32'h1040, pat_11, 1'b0);
        xfer(READ, 32'h0047, '0, 1'b0);
        chk("read_alias", hrdata, pat_11);

        // Top line index.
        xfer(WRITE, 32'hFC0, pat_5a, 1'b0);
        xfer(READ, 32'hFC0, '0, 1'b0);
        chk("read_line63", hrdata, pat_5a);

        // Reset on the capture edge: line 2 must stay zero.
        hreq = 1'b1; tick();
        haddr = 32'h80; hwrite = WRITE; hwdata = pat_de; hreq = 1'b0; tick();
        do_reset();
        xfer(READ, 32'h80, '0, 1'b0);
        chk("no_write_on_reset", hrdata, pat_zero);

        // Reset after capture (in the write wait state): line 3 is written.
        hreq = 1'b1; tick();
        haddr = 32'hC0; hwrite = WRITE; hwdata = pat_de; hreq = 1'b0; tick();
        tick();
        model_mem[3] = pat_de;
        exp_wr++;
        exp_hready = 1'b0;
        do_reset();
        xfer(READ, 32'hC0, '0, 1'b0);
        chk("write_kept_after_reset", hrdata, pat_de);

        // Back-to-back with hreq held high.
        do_reset();
        xfer(WRITE, 32'h100, pat_a5, 1'b1);
        xfer(READ, 32'h100, '0, 1'b0);
        chk("b2b_wr_cnt", {{(LINE_W-16){1'b0}}, wr_cnt}, {{(LINE_W-16){1'b0}}, 16'd1});
        chk("b2b_rd_cnt", {{(LINE_W-16){1'b0}}, rd_cnt}, {{(LINE_W-16){1'b0}}, 16'd1});
        chk("b2b_data", hrdata, pat_a5);

        // Saturation: preload counters near the top, then overrun them.
        dut.wr_cnt_q = 16'hFFFD; exp_wr = 16'hFFFD;
        dut.rd_cnt_q = 16'hFFFE; exp_rd = 16'hFFFE;
        for (int i = 0; i < 4; i++) xfer(WRITE, ADDR_W'(i * 64), pat_11, 1'b1);
        xfer(READ, 32'h0, '0, 1'b1);
        xfer(READ, 32'h0, '0, 1'b0);
        chk("wr_cnt_saturated", {{(LINE_W-16){1'b0}}, wr_cnt}, {{(LINE_W-16){1'b0}}, 16'hFFFF});
        chk("rd_cnt_saturated", {{(LINE_W-16){1'b0}}, rd_cnt}, {{(LINE_W-16){1'b0}}, 16'hFFFF});

        repeat (3) tick();
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
